axil_replay_mstr: RTL
=====================

# axil_replay_mstr

Replay-side counterpart of the AXI-lite master recorder. It consumes decoded log entries (header plus AW/W/AR payloads) and re-issues them as an AXI-lite initiator toward the CL slave under test. It sits between the replay log decoder and the CL's AXI-lite slave port. It bounds outstanding transactions and forwards read responses for checking.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum number of writes in flight, and separately the maximum number of reads in flight. Range 1..15.
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  log entry valid
- `in_ready`  out  1  log entry accepted when `in_valid & in_ready`
- `in_hdr`  in  3  channel-present bits: [0]=AW, [1]=W, [2]=AR
- `in_aw`  in  32  awaddr
- `in_w`  in  36  {wstrb[3:0], wdata[31:0]}
- `in_ar`  in  32  araddr
- `awaddr`, `awvalid`, `awready`  out/out/in  32/1/1  AXI-lite write address channel
- `wdata`, `wstrb`, `wvalid`, `wready`  out/out/out/in  32/4/1/1  AXI-lite write data channel
- `bresp`, `bvalid`, `bready`  in/in/out  2/1/1  AXI-lite write response channel
- `araddr`, `arvalid`, `arready`  out/out/in  32/1/1  AXI-lite read address channel
- `rdata`, `rresp`, `rvalid`, `rready`  in/in/in/out  32/2/1/1  AXI-lite read response channel
- `rd_valid`, `rd_ready`, `rd_data`, `rd_resp`  out/in/out/out  1/1/32/2  forwarded read responses
- `wr_out`, `rd_out`  out  4 each  in-flight write and read counts
- `err_cnt`  out  16  count of non-OKAY responses

## Operation
- States: IDLE and ISSUE.
- IDLE:
  - `in_ready = !rst && wr_out < MAX_OUTSTANDING && rd_out < MAX_OUTSTANDING`.
  - On accept, latch the payloads and the pending mask (equal to `in_hdr`).
  - `hdr==0`: the entry is consumed as a no-op and the block stays in IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - Each pending channel drives its valid from the registered payload.
  - Each channel clears its pending bit on its own handshake. Channels complete independently, in any order, and several may complete in the same cycle.
  - When the mask becomes zero, return to IDLE.
  - Once a valid is asserted, it and its payload stay stable until that channel's handshake.
- `wr_out`:
  - Increments on each AW handshake.
  - Decrements on each B handshake.
  - A simultaneous increment and decrement leaves it unchanged.
  - A decrement at 0 saturates at 0.
- `rd_out` follows the same rules using AR and R handshakes.
- `bready` is held at 1.
- `rready = rd_ready`, with `rd_valid = rvalid` and `rd_data`/`rd_resp` passed straight through combinationally.
- Reset mid-operation:
  - The in-flight entry is dropped.
  - All valids are low in the cycle after `rst` is sampled high.
  - Counters go to 0; late responses are absorbed without underflow.

## Timing
- Reset values:
  - Outputs: `in_ready`, `awvalid`, `wvalid`, `arvalid` = 0; `wr_out`, `rd_out`, `err_cnt` = 0; payload outputs = 0.
  - State: IDLE.
- An entry accepted at cycle N has its valids asserted at N+1.
- If the last pending handshake occurs at cycle M, `in_ready` can next be high at M+1. Peak throughput is one entry per 2 cycles.
- Counter updates are visible the cycle after the handshake. A response at cycle K can raise `in_ready` at K+1.
- The `rd_*` path adds zero latency.

## Configuration
- `AXIL_REPLAY_ERRCNT_EN` defined:
  - `err_cnt` increments once per B handshake with `bresp!=0`, and once per R handshake with `rresp!=0`.
  - If both occur in one cycle, it increments by 2.
  - It saturates at 16'hFFFF.
- `AXIL_REPLAY_ERRCNT_EN` undefined: `err_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Write entry: hdr=3'b011, aw=32'h10, w={4'hF,32'hDEAD_BEEF}, with `awready` and `wready` high. Expect awvalid/wvalid at N+1, addr and data exact, `wr_out`=1. Then bvalid with resp 0: `wr_out`=0, `err_cnt`=0.
- Skewed handshake: hdr=3'b011, `wready` held low for 3 cycles after AW handshakes. Expect `wvalid` and payload stable throughout, `awvalid` low after its handshake, and `in_ready` high the cycle after the W handshake.
- Read forward: hdr=3'b100, ar=32'h20. Respond `rdata`=32'h1234_5678, `rresp`=2'b10, and stall `rd_ready` for 2 cycles. Expect `rready` low during the stall, `rd_data` equal to the response, `rd_out` 1→0, and `err_cnt`=1 with the macro defined, 0 without.
- Outstanding limit: MAX_OUTSTANDING=2, no B responses, 3 write entries offered. Expect `in_ready` low after the second AW handshake with `wr_out`=2. One B response makes `in_ready` high the next cycle.
- Edge cases: a hdr=0 entry is accepted with no bus activity. Simultaneous AW and B handshakes keep `wr_out` unchanged. Asserting `rst` during ISSUE drops all valids the next cycle and zeroes the counters; a subsequent B keeps `wr_out`=0.

Source files
------------

// File: rtl/axil_replay_mstr.sv
// AXI-lite replay initiator: re-issues decoded log entries (AW/W/AR) toward a slave,
// bounds in-flight traffic and forwards read responses. Optional macro: AXIL_REPLAY_ERRCNT_EN.
module axil_replay_mstr #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_hdr,
    input  logic [31:0] in_aw,
    input  logic [35:0] in_w,
    input  logic [31:0] in_ar,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic [1:0]  rd_resp,
    output logic [3:0]  wr_out,
    output logic [3:0]  rd_out,
    output logic [15:0] err_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

    state_t      state_r;
    state_t      state_s;
    logic [2:0]  pend_r;
    logic [2:0]  pend_s;
    logic [31:0] aw_r;
    logic [35:0] w_r;
    logic [31:0] ar_r;
    logic        accept_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        ar_hs_s;
    logic        b_hs_s;
    logic        r_hs_s;

    // Saturating up/down in-flight counter; a simultaneous up and down cancels.
    function automatic logic [3:0] cnt_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + 4'd1;
            2'b01:   res = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    // Pending bits drive the valids directly, so valids are register outputs.
    assign awvalid = pend_r[0];
    assign wvalid  = pend_r[1];
    assign arvalid = pend_r[2];
    assign awaddr  = aw_r;
    assign wdata   = w_r[31:0];
    assign wstrb   = w_r[35:32];
    assign araddr  = ar_r;

    assign bready   = 1'b1;
    assign rready   = rd_ready;
    assign rd_valid = rvalid;
    assign rd_data  = rdata;
    assign rd_resp  = rresp;

    assign aw_hs_s  = awvalid & awready;
    assign w_hs_s   = wvalid & wready;
    assign ar_hs_s  = arvalid & arready;
    assign b_hs_s   = bvalid & bready;
    assign r_hs_s   = rvalid & rready;
    assign accept_s = in_valid & in_ready;

    // Entry acceptance: only from IDLE and only with headroom on both directions.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && (state_r == IDLE) && (wr_out < MAX_C) && (rd_out < MAX_C)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Next-state and pending-mask logic; each channel retires on its own handshake.
    always_comb begin
        state_s = state_r;
        pend_s  = pend_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    pend_s  = in_hdr;
                    state_s = (in_hdr == 3'b000) ? IDLE : ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                pend_s = pend_r & ~{ar_hs_s, w_hs_s, aw_hs_s};
                if (pend_s == 3'b000) begin
                    state_s = IDLE;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: begin
                state_s = IDLE;
                pend_s  = 3'b000;
            end
        endcase
    end

    // State and pending-mask registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pend_r  <= 3'b000;
        end else begin
            state_r <= state_s;
            pend_r  <= pend_s;
        end
    end

    // Payload capture on accept; held stable while the channel is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_r <= 32'h0000_0000;
            w_r  <= 36'h0_0000_0000;
            ar_r <= 32'h0000_0000;
        end else if (accept_s) begin
            aw_r <= in_aw;
            w_r  <= in_w;
            ar_r <= in_ar;
        end
    end

    // In-flight counters; responses arriving at zero (e.g. after reset) are absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_out <= 4'd0;
            rd_out <= 4'd0;
        end else begin
            wr_out <= cnt_next(wr_out, aw_hs_s, b_hs_s);
            rd_out <= cnt_next(rd_out, ar_hs_s, r_hs_s);
        end
    end

`ifdef AXIL_REPLAY_ERRCNT_EN
    // Saturating add of up to two error events per cycle.
    function automatic logic [15:0] err_next(input logic [15:0] cnt, input logic b_err, input logic r_err);
        logic [16:0] sum;
        sum = {1'b0, cnt} + 17'(b_err) + 17'(r_err);
        return (sum > 17'h0_FFFF) ? 16'hFFFF : sum[15:0];
    endfunction

    logic b_err_s;
    logic r_err_s;

    assign b_err_s = b_hs_s & (bresp != 2'b00);
    assign r_err_s = r_hs_s & (rresp != 2'b00);

    // Error response counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'h0000;
        end else begin
            err_cnt <= err_next(err_cnt, b_err_s, r_err_s);
        end
    end
`else
    logic unused_resp_s;

    assign unused_resp_s = ^{bresp, rresp};
    assign err_cnt       = 16'h0000;
`endif

endmodule
